// File: rtl/ll_multi_fifo_pkg.sv
// Shared types and constants for the linked-list multi-queue FIFO.
package ll_multi_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_NUM_FIFOS = 4;
  localparam int DEF_PTR_WIDTH = $clog2(DEF_DEPTH);
  localparam int DEF_SEL_WIDTH = $clog2(DEF_NUM_FIFOS);
  localparam int DEF_CNT_WIDTH = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_PTR_WIDTH-1:0] ptr_t;
  typedef logic [DEF_SEL_WIDTH-1:0] sel_t;
  typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

  // Ownership tag for back-pointer tracking: an entry is either on the free
  // list or linked into one of the data queues.
  localparam logic QUEUE_FREE = 1'b0;
  localparam logic QUEUE_DATA = 1'b1;

endpackage

// File: rtl/ll_multi_fifo_free_list.sv
// Circular buffer of free entry pointers. pop hands out the head pointer,
// push returns a released pointer to the tail. When the list is empty and
// both happen together, the released pointer is handed straight back out.
module ll_free_list import ll_multi_fifo_pkg::*; #(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pop,
  input  logic                 push,
  input  logic [PTR_WIDTH-1:0] push_ptr,
  output logic [PTR_WIDTH-1:0] pop_ptr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [PTR_WIDTH-1:0] ring [DEPTH];
  logic [PTR_WIDTH-1:0] rd_idx;
  logic [PTR_WIDTH-1:0] wr_idx;
  logic                 bypass;

  assign bypass  = pop & push & (count == '0);
  assign pop_ptr = bypass ? push_ptr : ring[rd_idx];

  // Ring pointers and occupancy; a bypass leaves the ring untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= PTR_WIDTH'(i);
      end
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= CNT_WIDTH'(DEPTH);
    end else if (!bypass) begin
      if (push) begin
        ring[wr_idx] <= push_ptr;
        wr_idx       <= wr_idx + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_idx <= rd_idx + PTR_WIDTH'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_WIDTH'(1);
      end else if (pop && !push) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ll_multi_fifo.sv
// Shared-buffer multi-queue FIFO: NUM_FIFOS linked lists threaded through one
// DEPTH-entry store, with per-queue caps, full-store push/pop bypass,
// registered read data and a sticky error flag for rejected requests.
module ll_multi_fifo import ll_multi_fifo_pkg::*; #(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int NUM_FIFOS    = DEF_NUM_FIFOS,
  parameter int MAX_PER_FIFO = DEPTH,
  parameter bit FULL_BYPASS  = 1'b1,
  parameter int PTR_WIDTH    = $clog2(DEPTH),
  parameter int SEL_WIDTH    = $clog2(NUM_FIFOS),
  parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [SEL_WIDTH-1:0] push_sel,
  input  logic [SEL_WIDTH-1:0] pop_sel,
  input  logic [WIDTH-1:0]     data_in,
  output logic [NUM_FIFOS-1:0] full,
  output logic [NUM_FIFOS-1:0] empty,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_out_vld,
  output logic [CNT_WIDTH-1:0] free_count,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(MAX_PER_FIFO);

  logic [WIDTH-1:0]     mem   [DEPTH];
  logic [PTR_WIDTH-1:0] nxt   [DEPTH];
  logic [PTR_WIDTH-1:0] head  [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] tail  [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] count [NUM_FIFOS];

  logic                 pop_ok;
  logic                 push_ok;
  logic                 push_to_empty;
  logic                 store_full;
  logic [PTR_WIDTH-1:0] pop_head;
  logic [PTR_WIDTH-1:0] push_ptr;
  int                   occ_sum;

  // Request qualification. A push into a queue that the same-cycle pop
  // drains to zero must relink the head rather than the old tail.
  always_comb begin
    pop_head      = head[pop_sel];
    store_full    = (free_count == '0);
    pop_ok        = pop & (count[pop_sel] != '0);
    push_ok       = push & (count[push_sel] != CAP) &
                    (~store_full | (FULL_BYPASS & pop_ok));
    push_to_empty = (count[push_sel] == '0) |
                    ((push_sel == pop_sel) & pop_ok &
                     (count[push_sel] == CNT_WIDTH'(1)));
  end

  // Per-queue status flags.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      full[q]  = (count[q] == CAP) | store_full;
      empty[q] = (count[q] == '0);
    end
  end

  ll_free_list #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_free_list (
    .clk      (clk),
    .rst      (rst),
    .pop      (push_ok),
    .push     (pop_ok),
    .push_ptr (pop_head),
    .pop_ptr  (push_ptr),
    .count    (free_count)
  );

  // Data store and link array; contents are don't-care until linked.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[push_ptr] <= data_in;
      if (!push_to_empty) begin
        nxt[tail[push_sel]] <= push_ptr;
      end
    end
  end

  // Queue heads/tails/counts, registered read port and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < NUM_FIFOS; q++) begin
        head[q]  <= '0;
        tail[q]  <= '0;
        count[q] <= '0;
      end
      data_out     <= '0;
      data_out_vld <= 1'b0;
      err          <= 1'b0;
    end else begin
      data_out_vld <= pop_ok;
      if (pop_ok) begin
        data_out      <= mem[pop_head];
        head[pop_sel] <= nxt[pop_head];
      end
      if (push_ok) begin
        tail[push_sel] <= push_ptr;
        if (push_to_empty) begin
          head[push_sel] <= push_ptr;
        end
      end
      for (int q = 0; q < NUM_FIFOS; q++) begin
        if (push_ok && push_sel == SEL_WIDTH'(q) &&
            !(pop_ok && pop_sel == SEL_WIDTH'(q))) begin
          count[q] <= count[q] + CNT_WIDTH'(1);
        end else if (pop_ok && pop_sel == SEL_WIDTH'(q) &&
                     !(push_ok && push_sel == SEL_WIDTH'(q))) begin
          count[q] <= count[q] - CNT_WIDTH'(1);
        end
      end
      if ((push && !push_ok) || (pop && !pop_ok)) begin
        err <= 1'b1;
      end
    end
  end

  // Total occupancy across queues, for the conservation check below.
  always_comb begin
    occ_sum = 0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      occ_sum = occ_sum + int'(count[q]);
    end
  end

  // Every entry is either linked into a queue or on the free list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_sum + int'(free_count) == DEPTH);
    end
  end

endmodule
